dct_mcu_sched: RTL and testbench
================================

Name: dct_mcu_sched

Overview:
- Scheduler in front of the 2-D DCT pipeline. It shares one DCT between three component sources (Y, Cb, Cr).
- Sequences 8x8 blocks in MCU order (4:2:0 = Y,Y,Y,Y,Cb,Cr; 4:4:4 = Y,Cb,Cr) and forwards rows as the DCT row stream.
- Carries a component tag through the pipeline so the downstream quantizer picks the luma or chroma table for each coefficient beat.

Parameters:
- DW, 8, source pixel/row element width (signed)
- QW, 15, DCT coefficient width, pass-through only
- TAG_DEPTH, 4, max blocks in flight between DCT input and zigzag output (power of 2)
- MCUW, 16, width of MCU count

Ports:
- clk  in  1  clock; single clock domain
- resetn  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse; latches cfg, starts frame
- cfg_420  in  1  1 = 4:2:0 MCU (6 blocks), 0 = 4:4:4 (3 blocks)
- cfg_num_mcu  in  MCUW  MCUs in frame; 0 = empty frame
- src_data  in  3x8xDW  per-component row (index 0=Y, 1=Cb, 2=Cr)
- src_valid  in  3  per-component row valid
- src_hold  out  3  per-component hold
- di  out  8xDW  row to DCT
- di_valid  out  1  row valid
- di_hold  in  1  DCT backpressure
- di_cnt  out  3  row index within block
- q_valid  in  1  DCT/zigzag output beat valid (observed, not driven)
- q_hold  in  1  downstream hold (observed)
- q_cnt  in  5  beat index within block, 0..31
- q_comp  out  2  component tag of current output beat (0=Y, 1=Cb, 2=Cr)
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when last block's last beat leaves

Behaviour:
- Reset values: src_hold=3'b111, di_valid=0, di_cnt=0, q_comp=0, busy=0, frame_done=0. FSM=IDLE, tag FIFO empty, all counters 0. di is don't-care but driven 0 at reset.
- Transfer rule: a row moves when valid && !hold. An asserted valid holds until accepted.
- FSM states:
  - IDLE: frame_start with cfg_num_mcu!=0 -> ARB. With cfg_num_mcu==0 -> DRAIN. frame_start in other states is ignored.
  - ARB: waits for a free tag slot, then pushes the slot's component into the tag FIFO and -> ROWS. If the FIFO is full, stays in ARB. A tag pop in the same cycle frees the slot, so the push proceeds.
  - ROWS: grant = slot component. di = src_data[grant]; di_valid = src_valid[grant]. src_hold[grant] = di_hold; all other src_hold = 1. di_cnt increments per transfer.
    - Transfer at di_cnt==7 advances the slot (wraps at 6 or 3 per cfg_420).
    - On slot wrap, the MCU counter increments.
    - Last slot of last MCU -> DRAIN; otherwise -> ARB.
  - DRAIN: busy stays 1 until the tag FIFO is empty. Then frame_done pulses for 1 cycle -> IDLE.
- busy=1 in every state except IDLE.
- Input datapath is combinational: zero added latency and no registers between src and di.
- Output side:
  - q_comp = tag FIFO head.
  - Pop when q_valid && !q_hold && q_cnt==31.
  - Push and pop in the same cycle keep the count unchanged.
  - A pop with the FIFO empty is a protocol error: assertion fires, FIFO state unchanged.
- Cfg latched at frame_start; changes mid-frame have no effect.
- Reset mid-frame: all state returns to reset values in the next cycle. No frame_done is issued.

Optional Feature:
- DCT_SCHED_PERF_EN defined:
  - Adds outputs perf_src_stall[31:0] (cycles in ROWS with src_valid[grant]=0) and perf_dct_stall[31:0] (cycles with di_valid && di_hold).
  - Both saturate at all-ones and clear on frame_start.
- Undefined: ports and counters absent; no other behaviour changes.

Decomposition:
- Package dct_sched_pkg holds:
  - comp_e enum (COMP_Y=0, COMP_CB=1, COMP_CR=2)
  - state_e enum (IDLE, ARB, ROWS, DRAIN)
  - MCU_SEQ_420 and MCU_SEQ_444 slot-to-component constant arrays
- One sub-module: dct_tag_fifo. Synchronous FIFO, width 2, depth TAG_DEPTH, with push/pop/full/empty/head.

Test Plan:
- 4:4:4, cfg_num_mcu=1, all sources always valid, no holds -> 24 consecutive row transfers, grant order Y,Cb,Cr with 8 rows each, di_cnt 0..7 repeating. After 3x32 output beats, q_comp sequence 0,1,2 and a single frame_done.
- 4:2:0, cfg_num_mcu=2 -> block order Y,Y,Y,Y,Cb,Cr twice (12 blocks, 96 rows). Non-granted src_hold stay 1 throughout.
- di_hold asserted for 5 cycles at di_cnt=3 -> di and di_cnt stable, src_hold[grant]=1; transfer resumes with row 3 and no row is lost or duplicated.
- q_valid held 0 with TAG_DEPTH=4 -> exactly 4 blocks enter, FSM parks in ARB. Single q beat with q_cnt=31 in the same cycle as the push -> 5th block starts immediately.
- cfg_num_mcu=0 -> busy high for 1 cycle (DRAIN), frame_done pulses, no di_valid.
- resetn low for 1 cycle mid-frame (row 5 of the Cb block) -> next cycle all outputs at reset values; a new frame_start then runs a full correct frame.

Source files
------------

// File: rtl/dct_mcu_sched_pkg.sv
// Shared types for the DCT MCU scheduler: component tags, FSM states
// and the per-slot component order for 4:2:0 and 4:4:4 MCUs.
package dct_sched_pkg;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ROWS  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam comp_e MCU_SEQ_420 [6] = '{
    COMP_Y, COMP_Y, COMP_Y, COMP_Y, COMP_CB, COMP_CR
  };

  localparam comp_e MCU_SEQ_444 [3] = '{
    COMP_Y, COMP_CB, COMP_CR
  };

  function automatic comp_e slot_comp(
    input logic       is420,
    input logic [2:0] slot
  );
    if (is420)
      return (slot < 3'd6) ? MCU_SEQ_420[slot] : COMP_Y;
    return (slot < 3'd3) ? MCU_SEQ_444[slot[1:0]] : COMP_Y;
  endfunction

endpackage

// File: rtl/dct_tag_fifo.sv
// Component-tag FIFO between DCT input and zigzag output.
// A pop frees a slot for a push in the same cycle when full.
module dct_tag_fifo
  import dct_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  push,
  input  logic  pop,
  input  comp_e din,
  output logic  full,
  output logic  empty,
  output comp_e head
);

  localparam int AW = $clog2(DEPTH);

  comp_e         mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? COMP_Y : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push}
                 - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Popping an empty FIFO is an upstream protocol error
  assert property (@(posedge clk) disable iff (!resetn)
    !(pop && empty));

endmodule

// File: rtl/dct_mcu_sched.sv
// MCU-order block scheduler feeding one shared 2-D DCT from Y/Cb/Cr.
// Define DCT_SCHED_PERF_EN to add saturating stall counters.
module dct_mcu_sched
  import dct_sched_pkg::*;
#(
  parameter int DW        = 8,
  parameter int QW        = 15,
  parameter int TAG_DEPTH = 4,
  parameter int MCUW      = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    frame_start,
  input  logic                    cfg_420,
  input  logic [MCUW-1:0]         cfg_num_mcu,
  input  logic [2:0][7:0][DW-1:0] src_data,
  input  logic [2:0]              src_valid,
  output logic [2:0]              src_hold,
  output logic [7:0][DW-1:0]      di,
  output logic                    di_valid,
  input  logic                    di_hold,
  output logic [2:0]              di_cnt,
  input  logic                    q_valid,
  input  logic                    q_hold,
  input  logic [4:0]              q_cnt,
  output logic [1:0]              q_comp,
`ifdef DCT_SCHED_PERF_EN
  output logic [31:0]             perf_src_stall,
  output logic [31:0]             perf_dct_stall,
`endif
  output logic                    busy,
  output logic                    frame_done
);

  if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0
      || QW < 1 || DW < 1) begin : g_bad_param
    $error("dct_mcu_sched: unsupported parameters");
  end

  state_e          state;
  logic [2:0]      slot;
  logic            is420;
  logic [MCUW-1:0] num_mcu;
  logic [MCUW-1:0] mcu_cnt;
  comp_e           grant;
  comp_e           tag_head;
  logic            in_rows;
  logic            xfer;
  logic            q_pop;
  logic            tag_push;
  logic            tag_full;
  logic            tag_empty;
  logic            last_slot;
  logic            last_mcu;

  assign grant     = slot_comp(is420, slot);
  assign in_rows   = (state == ROWS);
  assign xfer      = di_valid && !di_hold;
  assign q_pop     = q_valid && !q_hold && (q_cnt == 5'd31);
  assign tag_push  = (state == ARB) && (!tag_full || q_pop);
  assign last_slot = (slot == (is420 ? 3'd5 : 3'd2));
  assign last_mcu  = (mcu_cnt == num_mcu - MCUW'(1));
  assign busy       = (state != IDLE);
  assign frame_done = (state == DRAIN) && tag_empty;
  assign q_comp     = tag_head;

  // Zero-latency row mux: only the granted source sees DCT backpressure
  always_comb begin
    di       = '0;
    di_valid = 1'b0;
    src_hold = 3'b111;
    if (in_rows) begin
      di              = src_data[grant];
      di_valid        = src_valid[grant];
      src_hold[grant] = di_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      slot    <= '0;
      is420   <= 1'b0;
      num_mcu <= '0;
      mcu_cnt <= '0;
      di_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            is420   <= cfg_420;
            num_mcu <= cfg_num_mcu;
            slot    <= '0;
            mcu_cnt <= '0;
            di_cnt  <= '0;
            state   <= (cfg_num_mcu != '0) ? ARB : DRAIN;
          end
        end
        ARB: begin
          if (tag_push)
            state <= ROWS;
        end
        ROWS: begin
          if (xfer) begin
            di_cnt <= di_cnt + 3'd1;
            if (di_cnt == 3'd7) begin
              if (last_slot) begin
                slot    <= '0;
                mcu_cnt <= mcu_cnt + MCUW'(1);
                state   <= last_mcu ? DRAIN : ARB;
              end else begin
                slot  <= slot + 3'd1;
                state <= ARB;
              end
            end
          end
        end
        DRAIN: begin
          if (tag_empty)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCT_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn || frame_start) begin
      perf_src_stall <= '0;
      perf_dct_stall <= '0;
    end else begin
      if (in_rows && !src_valid[grant]
          && perf_src_stall != '1)
        perf_src_stall <= perf_src_stall + 32'd1;
      if (di_valid && di_hold
          && perf_dct_stall != '1)
        perf_dct_stall <= perf_dct_stall + 32'd1;
    end
  end
`endif

  dct_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (tag_push),
    .pop    (q_pop),
    .din    (grant),
    .full   (tag_full),
    .empty  (tag_empty),
    .head   (tag_head)
  );

endmodule

// File: tb/tb_dct_mcu_sched.sv
// Bench for dct_mcu_sched: random rows/holds/beats checked against
// a block-list model built from the MCU ordering rules.
module tb_dct_mcu_sched;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 frame_start;
  logic                 cfg_420;
  logic [15:0]          cfg_num_mcu;
  logic [2:0][7:0][7:0] src_data;
  logic [2:0]           src_valid;
  logic [2:0]           src_hold;
  logic [7:0][7:0]      di;
  logic                 di_valid;
  logic                 di_hold;
  logic [2:0]           di_cnt;
  logic                 q_valid;
  logic                 q_hold;
  logic [4:0]           q_cnt;
  logic [1:0]           q_comp;
  logic                 busy;
  logic                 frame_done;

  always #5 clk = ~clk;

  dct_mcu_sched #(
    .DW(8), .QW(15), .TAG_DEPTH(4), .MCUW(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .frame_start(frame_start), .cfg_420(cfg_420),
    .cfg_num_mcu(cfg_num_mcu),
    .src_data(src_data), .src_valid(src_valid),
    .src_hold(src_hold),
    .di(di), .di_valid(di_valid), .di_hold(di_hold),
    .di_cnt(di_cnt),
    .q_valid(q_valid), .q_hold(q_hold), .q_cnt(q_cnt),
    .q_comp(q_comp),
    .busy(busy), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int blocks[$];
  int cq[$];
  int blk_idx, row_m, beat, completed, popped;
  bit frame_act, rows_done, all_done, pend;
  bit p420;
  int pn;

  // stimulus knobs
  int vpct = 100, hpct = 0, qpct = 100, qhpct = 0;
  bit q_en = 1'b1;
  bit hold3 = 1'b0;
  int force_hold = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    blocks.delete();
    cq.delete();
    for (int m = 0; m < pn; m++) begin
      if (p420) begin
        for (int k = 0; k < 4; k++) blocks.push_back(0);
        blocks.push_back(1);
        blocks.push_back(2);
      end else begin
        blocks.push_back(0);
        blocks.push_back(1);
        blocks.push_back(2);
      end
    end
    blk_idx = 0; row_m = 0; beat = 0;
    completed = 0; popped = 0;
    frame_act = 1'b1;
    rows_done = (pn == 0);
    all_done  = (pn == 0);
  endtask

  task automatic sample();
    int comp;
    logic [2:0] hexp;
    bit feed;
    @(negedge clk);
    check("busy", busy, frame_act);
    check("frame_done", frame_done, all_done);
    feed = frame_act && !rows_done;
    if (feed) begin
      comp = blocks[blk_idx];
      if (di_valid) begin
        check("valid_src", src_valid[comp], 1);
        check("di_cnt", di_cnt, row_m);
        check("di", di, src_data[comp]);
        hexp = 3'b111;
        hexp[comp] = di_hold;
        check("src_hold", src_hold, hexp);
        if (row_m == 0)
          check("tags_inflight", (completed - popped) <= 3, 1);
        if (!di_hold) begin
          row_m++;
          if (row_m == 8) begin
            row_m = 0;
            cq.push_back(comp);
            completed++;
            blk_idx++;
            if (blk_idx == blocks.size()) rows_done = 1'b1;
          end
        end
      end else begin
        hexp = src_hold;
        hexp[comp] = 1'b1;
        check("src_hold_other", hexp, 3'b111);
      end
    end else begin
      check("di_valid_off", di_valid, 0);
      check("src_hold_off", src_hold, 3'b111);
    end
    if (cq.size() > 0) begin
      check("q_comp", q_comp, cq[0]);
      if (q_valid && !q_hold) begin
        if (beat == 31) begin
          void'(cq.pop_front());
          popped++;
          beat = 0;
        end else beat++;
      end
    end
    if (all_done) begin
      frame_act = 1'b0;
      all_done  = 1'b0;
    end else if (frame_act && rows_done && cq.size() == 0)
      all_done = 1'b1;
    if (pend) begin
      pend = 1'b0;
      init_model();
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 3; c++) begin
      src_data[c]  = {$urandom, $urandom};
      src_valid[c] = ($urandom_range(99) < vpct);
    end
    if (hold3 && frame_act && !rows_done && row_m == 3) begin
      force_hold = 5;
      hold3 = 1'b0;
    end
    if (force_hold > 0) begin
      di_hold = 1'b1;
      force_hold--;
    end else di_hold = ($urandom_range(99) < hpct);
    cfg_420     = 1'($urandom);
    cfg_num_mcu = 16'($urandom);
    frame_start = frame_act && !rows_done && !pend
                  && ($urandom_range(15) == 0);
    if (q_en && cq.size() > 0) begin
      q_valid = ($urandom_range(99) < qpct);
      q_hold  = ($urandom_range(99) < qhpct);
      q_cnt   = 5'(beat);
    end else begin
      q_valid = 1'b0;
      q_hold  = 1'($urandom);
      q_cnt   = 5'($urandom);
    end
  endtask

  task automatic tick();
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic start_frame(input bit is420, input int n);
    frame_start = 1'b1;
    cfg_420     = is420;
    cfg_num_mcu = 16'(n);
    p420 = is420;
    pn   = n;
    pend = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && (frame_act || pend); i++)
      tick();
    check("frame_timeout", frame_act || pend, 0);
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    q_valid     = 1'b0;
    frame_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_src_hold", src_hold, 3'b111);
    check("rst_di_valid", di_valid, 0);
    check("rst_di_cnt", di_cnt, 0);
    check("rst_di", di, 0);
    check("rst_q_comp", q_comp, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    blocks.delete();
    cq.delete();
    frame_act = 1'b0; rows_done = 1'b0;
    all_done = 1'b0; pend = 1'b0;
    force_hold = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive();
  endtask

  initial begin
    int guard;
    resetn = 1'b0; frame_start = 1'b0; cfg_420 = 1'b0;
    cfg_num_mcu = '0; src_data = '0; src_valid = '0;
    di_hold = 1'b0; q_valid = 1'b0; q_hold = 1'b0; q_cnt = '0;
    do_reset();

    // 4:4:4, one MCU, no stalls
    vpct = 100; hpct = 0; qpct = 100; qhpct = 0; q_en = 1'b1;
    start_frame(1'b0, 1);
    wait_done(400);

    // 4:2:0, two MCUs, random stalls on both sides
    vpct = 70; hpct = 25; qpct = 70; qhpct = 20;
    start_frame(1'b1, 2);
    wait_done(3000);

    // DCT hold for 5 cycles at row 3
    vpct = 100; hpct = 0; qpct = 100; qhpct = 0;
    hold3 = 1'b1;
    start_frame(1'b0, 1);
    wait_done(600);
    check("hold3_applied", hold3, 0);

    // tag FIFO fills and parks; one final beat releases block 5
    q_en = 1'b0;
    start_frame(1'b0, 2);
    repeat (80) tick();
    check("park_blocks", completed, 4);
    #1;
    check("park_di_valid", di_valid, 0);
    check("park_busy", busy, 1);
    q_valid = 1'b1; q_hold = 1'b0; q_cnt = 5'd31; beat = 31;
    tick();
    #1;
    check("park_resume_valid", di_valid, 1);
    check("park_resume_cnt", di_cnt, 0);
    q_en = 1'b1;
    wait_done(2000);

    // empty frame
    start_frame(1'b1, 0);
    wait_done(10);

    // reset at row 5 of the Cb block, then a clean frame
    start_frame(1'b0, 1);
    guard = 0;
    while (!(frame_act && !rows_done && blocks[blk_idx] == 1
             && row_m == 5) && guard < 200) begin
      tick();
      guard++;
    end
    check("reach_cb_row5", guard < 200, 1);
    do_reset();
    repeat (5) tick();
    start_frame(1'b0, 1);
    wait_done(600);

    // random configurations
    for (int i = 0; i < 4; i++) begin
      vpct = $urandom_range(100, 50);
      hpct = $urandom_range(30);
      qpct = $urandom_range(100, 50);
      qhpct = $urandom_range(30);
      start_frame(1'($urandom_range(1)), $urandom_range(3, 1));
      wait_done(6000);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
